pwm_bridge_nch: RTL and testbench

Parametrised N-channel successor to the fixed two-motor FIFO-to-PWM bridge. It accepts 32-bit command words through a write-side FIFO port and decodes per-channel SET, GET and STOP_ALL commands. It drives NCH direction/enable outputs from internal PWM generators and returns GET status words through a read-side FIFO port. It sits between the host stream endpoints and the motor drivers.

---
 rtl/pwm_bridge_pkg.sv | 23 ++
 rtl/pwm_bridge_nch_fifo.sv | 50 +++++
 rtl/pwm_bridge_nch.sv | 155 +++++++++++++++
 tb/tb_pwm_bridge_nch.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_bridge_pkg.sv
// pwm_bridge_pkg: command opcodes, command/response field positions and FSM states for pwm_bridge_nch
package pwm_bridge_pkg;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_SET  = 2'b01;
    localparam logic [1:0] OP_GET  = 2'b10;
    localparam logic [1:0] OP_STOP = 2'b11;

    localparam int OP_HI   = 31;
    localparam int OP_LO   = 30;
    localparam int CH_HI   = 29;
    localparam int CH_LO   = 26;
    localparam int DIR_BIT = 15;
    localparam int ERR_BIT = 31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/pwm_bridge_nch_fifo.sv
// sync_fifo: single-clock FIFO with registered read data; a push into a full FIFO is accepted only alongside a pop
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    output logic             full,
    output logic [WIDTH-1:0] dout,
    input  logic             rd_en,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CAP = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic push, pop;

    assign empty = cnt == '0;
    assign full = cnt == CAP;
    assign pop = rd_en && !empty;
    assign push = wr_en && (!full || pop);

    // storage needs no reset: entries are only read behind the occupancy count
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end

    // pointers, occupancy and registered read data; dout holds when nothing is popped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
            dout <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) begin
                rp <= rp + 1'b1;
                dout <= mem[rp];
            end
            cnt <= cnt + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end

endmodule

// File: rtl/pwm_bridge_nch.sv
// pwm_bridge_nch: N-channel command-FIFO to PWM motor bridge; dead time on direction change under PWM_BRIDGE_DEADTIME_EN
module pwm_bridge_nch
    import pwm_bridge_pkg::*;
#(
    parameter int NCH = 4,
    parameter int DUTY_W = 15,
    parameter int FIFO_DEPTH = 16,
    parameter int DEADTIME = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     din,
    input  logic            wr_en,
    output logic            full,
    output logic [31:0]     dout,
    input  logic            rd_en,
    output logic            empty,
    output logic [NCH-1:0]  dir_out,
    output logic [NCH-1:0]  en_out
);
    localparam int DT_W = $clog2(DEADTIME + 2);

    logic [31:0] in_dout, cmd, resp;
    logic in_empty, in_rd, out_full, out_wr;
    state_t state;
    logic [1:0] op;
    logic [3:0] ch;
    logic ch_ok, exec_set, exec_stop;
    logic [DUTY_W-1:0] cnt;
    logic [DUTY_W-1:0] duty [NCH];
    logic [NCH-1:0] dir, set_wr;
    logic unused_bits;

    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) input_fifo (
        .clk(clk),
        .rst(rst),
        .din(din),
        .wr_en(wr_en),
        .full(full),
        .dout(in_dout),
        .rd_en(in_rd),
        .empty(in_empty)
    );

    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) output_fifo (
        .clk(clk),
        .rst(rst),
        .din(resp),
        .wr_en(out_wr),
        .full(out_full),
        .dout(dout),
        .rd_en(rd_en),
        .empty(empty)
    );

    assign op = cmd[OP_HI:OP_LO];
    assign ch = cmd[CH_HI:CH_LO];
    assign ch_ok = 32'(ch) < NCH;
    assign exec_set = state == EXEC && op == OP_SET && ch_ok;
    assign exec_stop = state == EXEC && op == OP_STOP;
    assign in_rd = state == IDLE && !in_empty;
    assign out_wr = state == RESP && !out_full;
    assign unused_bits = ^{cmd, DEADTIME[0]};

    // one command at a time: pop, latch the popped word, decode, then optionally queue a GET response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cmd <= '0;
        end else begin
            if (state == FETCH) cmd <= in_dout;
            state <= (state == IDLE)  ? (in_empty ? IDLE : FETCH) :
                     (state == FETCH) ? EXEC :
                     (state == EXEC)  ? (op == OP_GET ? RESP : IDLE) :
                     (out_full ? RESP : IDLE);
        end
    end

    // shared free-running PWM counter, wraps naturally at 2^DUTY_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else cnt <= cnt + 1'b1;
    end

    // GET response: valid channels report dir and duty, out-of-range channels set the error flag
    always_comb begin
        resp = '0;
        resp[CH_HI:CH_LO] = ch;
        resp[ERR_BIT] = !ch_ok;
        for (int k = 0; k < NCH; k++) begin
            if (ch == 4'(k)) begin
                resp[DIR_BIT] = dir[k];
                resp[DUTY_W-1:0] = duty[k];
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [DUTY_W-1:0] d;
        logic r, dir_q, en_q;

        assign set_wr[i] = exec_set && ch == 4'(i);
        assign duty[i] = d;
        assign dir[i] = r;
        assign dir_out[i] = dir_q;
        assign en_out[i] = en_q;

        // commanded duty/dir; STOP_ALL clears duty and keeps the direction
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                d <= '0;
                r <= 1'b0;
            end else if (exec_stop) begin
                d <= '0;
            end else if (set_wr[i]) begin
                d <= cmd[DUTY_W-1:0];
                r <= cmd[DIR_BIT];
            end
        end

`ifdef PWM_BRIDGE_DEADTIME_EN
        logic [DT_W-1:0] dt;

        // a direction change (re)arms the dead time; same-direction SETs and STOP_ALL leave it running
        always_ff @(posedge clk or posedge rst) begin
            if (rst) dt <= '0;
            else if (set_wr[i] && cmd[DIR_BIT] != r) dt <= DT_W'(DEADTIME);
            else if (dt != '0) dt <= dt - 1'b1;
        end

        // enable held low and old direction kept until the dead time expires
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dir_q <= 1'b0;
                en_q <= 1'b0;
            end else begin
                dir_q <= (dt == '0) ? r : dir_q;
                en_q <= dt == '0 && cnt < d;
            end
        end
`else
        // registered PWM compare; direction and duty take effect together
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dir_q <= 1'b0;
                en_q <= 1'b0;
            end else begin
                dir_q <= r;
                en_q <= cnt < d;
            end
        end
`endif
    end

endmodule

// File: tb/tb_pwm_bridge_nch.sv
// tb_pwm_bridge_nch: randomized self-checking bench for pwm_bridge_nch against a command-level reference model
module tb_pwm_bridge_nch;
    localparam int NCH = 4;
    localparam int DUTY_W = 15;
    localparam int DEPTH = 16;
    localparam int DT = 8;
    localparam int PERIOD = 1 << DUTY_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] din = '0;
    logic wr_en = 1'b0;
    logic rd_en = 1'b0;
    logic full, empty;
    logic [31:0] dout;
    logic [NCH-1:0] dir_out, en_out;

    int checks = 0;
    int failures = 0;
    int m_duty [NCH];
    bit m_dir [NCH];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    pwm_bridge_nch #(.NCH(NCH), .DUTY_W(DUTY_W), .FIFO_DEPTH(DEPTH), .DEADTIME(DT)) dut (
        .clk(clk),
        .rst(rst),
        .din(din),
        .wr_en(wr_en),
        .full(full),
        .dout(dout),
        .rd_en(rd_en),
        .empty(empty),
        .dir_out(dir_out),
        .en_out(en_out)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk(input int op, input int ch, input int d, input int du);
        return (32'(op) << 30) | (32'(ch) << 26) | (32'(d & 1) << 15) | 32'(du & 32'h7FFF);
    endfunction

    // command semantics at the level of the command set: state arrays plus a queue of expected responses
    function automatic void model(input logic [31:0] w);
        int op;
        int ch;
        op = int'(w[31:30]);
        ch = int'(w[29:26]);
        if (op == 1 && ch < NCH) begin
            m_duty[ch] = int'(w[14:0]) % PERIOD;
            m_dir[ch] = w[15];
        end else if (op == 3) begin
            foreach (m_duty[k]) m_duty[k] = 0;
        end else if (op == 2) begin
            if (ch < NCH) exp_q.push_back(32'(ch) * 32'h0400_0000 + 32'(m_dir[ch]) * 32'h8000 + 32'(m_duty[ch]));
            else exp_q.push_back(32'h8000_0000 + 32'(ch) * 32'h0400_0000);
        end
    endfunction

    task automatic push(input logic [31:0] w);
        @(negedge clk);
        din = w;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic send(input logic [31:0] w);
        push(w);
        model(w);
    endtask

    task automatic read_check(input logic [31:0] expv, input string nm);
        int t;
        t = 0;
        while (empty && t < 300) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (empty) begin
            failures++;
            $display("FAIL %s: no response within 300 cycles, required %h", nm, expv);
        end else begin
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
            if (dout !== expv) begin
                failures++;
                $display("FAIL %s: dout=%h required %h", nm, dout, expv);
            end
        end
    endtask

    task automatic drain(input string nm);
        while (exp_q.size() > 0) read_check(exp_q.pop_front(), nm);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if ({full, empty, dout} !== {1'b0, 1'b1, 32'h0}) begin
            failures++;
            $display("FAIL reset_flags: full=%b empty=%b dout=%h required 0 1 0", full, empty, dout);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({dir_out, en_out} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: dir_out=%b en_out=%b required 0 0", dir_out, en_out);
        end
    endtask

    task automatic test_set_latency;
        int lat;
`ifdef PWM_BRIDGE_DEADTIME_EN
        lat = 4 + DT;
`else
        lat = 4;
`endif
        send(mk(1, 2, 1, 16'h4000));
        repeat (lat - 1) @(negedge clk);
        checks++;
        if (dir_out !== 4'b0000) begin
            failures++;
            $display("FAIL set_early: dir_out=%b required 0000 one cycle before latency", dir_out);
        end
        @(negedge clk);
        checks++;
        if (dir_out !== 4'b0100) begin
            failures++;
            $display("FAIL set_latency: dir_out=%b required 0100", dir_out);
        end
    endtask

    task automatic test_pwm;
        int hi [NCH];
        send(mk(1, 0, 0, 16'h7FFF));
        send(mk(1, 1, 0, 0));
        send(mk(1, 3, int'($urandom_range(0, 1)), int'($urandom_range(1, 16'h7FFE))));
        repeat (40) @(negedge clk);
        foreach (hi[k]) hi[k] = 0;
        for (int c = 0; c < PERIOD; c++) begin
            @(negedge clk);
            for (int k = 0; k < NCH; k++) hi[k] += int'(en_out[k]);
        end
        for (int k = 0; k < NCH; k++) begin
            checks++;
            if (hi[k] != m_duty[k]) begin
                failures++;
                $display("FAIL pwm_high_count ch%0d: %0d high cycles, required %0d", k, hi[k], m_duty[k]);
            end
        end
        checks++;
        if (dir_out !== {m_dir[3], m_dir[2], m_dir[1], m_dir[0]}) begin
            failures++;
            $display("FAIL pwm_dir: dir_out=%b required %b", dir_out, {m_dir[3], m_dir[2], m_dir[1], m_dir[0]});
        end
    endtask

    task automatic test_get;
        send(mk(1, 3, 0, 16'h0123));
        push(mk(2, 3, 0, 0));
        push(mk(2, 9, 0, 0));
        read_check(32'h0C00_0123, "get_ch3");
        read_check(32'hA400_0000, "get_ch9_err");
        send(mk(3, 0, 0, 0));
        push(mk(2, 2, 0, 0));
        read_check(32'h0800_8000, "get_after_stop");
        repeat (10) @(negedge clk);
        checks++;
        if (en_out !== '0) begin
            failures++;
            $display("FAIL stop_all_en: en_out=%b required 0000", en_out);
        end
    endtask

    task automatic test_dir_change;
        int lows;
        send(mk(1, 1, 0, 16'h7FFF));
        repeat (40) @(negedge clk);
        send(mk(1, 1, 1, 16'h7FFF));
        repeat (3) @(negedge clk);
        lows = 0;
`ifdef PWM_BRIDGE_DEADTIME_EN
        for (int k = 0; k < DT; k++) begin
            @(negedge clk);
            lows += int'(!en_out[1]);
            checks++;
            if (dir_out[1] !== 1'b0) begin
                failures++;
                $display("FAIL deadtime_dir_hold: dir_out[1]=%b required 0 at dead-time cycle %0d", dir_out[1], k);
            end
        end
        checks++;
        if (lows != DT) begin
            failures++;
            $display("FAIL deadtime_gap: %0d low cycles, required %0d", lows, DT);
        end
        @(negedge clk);
        checks++;
        if (dir_out[1] !== 1'b1) begin
            failures++;
            $display("FAIL deadtime_flip: dir_out[1]=%b required 1", dir_out[1]);
        end
`else
        @(negedge clk);
        checks++;
        if (dir_out[1] !== 1'b1) begin
            failures++;
            $display("FAIL dir_flip: dir_out[1]=%b required 1", dir_out[1]);
        end
        for (int k = 0; k < DT; k++) begin
            @(negedge clk);
            lows += int'(!en_out[1]);
        end
        checks++;
        if (lows > 1) begin
            failures++;
            $display("FAIL dir_no_gap: %0d low cycles after flip, required at most 1", lows);
        end
`endif
    endtask

    task automatic test_backpressure;
        for (int k = 0; k < DEPTH + 1; k++) send(mk(2, int'($urandom_range(0, 15)), 0, 0));
        repeat (100) @(negedge clk);
        send(mk(1, 1, 0, 0));
        for (int k = 0; k < DEPTH - 1; k++) send(mk(2, int'($urandom_range(0, 15)), 0, 0));
        checks++;
        if (full !== 1'b1) begin
            failures++;
            $display("FAIL input_full: full=%b required 1", full);
        end
        push(mk(2, 5, 0, 0));
        repeat (20) @(negedge clk);
        checks++;
        if (dir_out[1] !== 1'b1) begin
            failures++;
            $display("FAIL stall_set: dir_out[1]=%b required 1 while stalled", dir_out[1]);
        end
        drain("backpressure_resp");
        repeat (40) @(negedge clk);
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL dropped_word: empty=%b required 1 after drain", empty);
        end
        checks++;
        if (dir_out[1] !== m_dir[1]) begin
            failures++;
            $display("FAIL set_after_stall: dir_out[1]=%b required %b", dir_out[1], m_dir[1]);
        end
    endtask

    task automatic test_random;
        for (int k = 0; k < 24; k++) begin
            send(mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), int'($urandom_range(0, 16'h7FFF))));
        end
        repeat (100) @(negedge clk);
        for (int k = 0; k < NCH; k++) model(mk(2, k, 0, 0));
        for (int k = 0; k < NCH; k++) push(mk(2, k, 0, 0));
        drain("random_resp");
        repeat (20) @(negedge clk);
        checks++;
        if (dir_out !== {m_dir[3], m_dir[2], m_dir[1], m_dir[0]}) begin
            failures++;
            $display("FAIL random_dir: dir_out=%b required %b", dir_out, {m_dir[3], m_dir[2], m_dir[1], m_dir[0]});
        end
    endtask

    task automatic test_reset_midstream;
        int hi;
        for (int k = 0; k < NCH; k++) send(mk(1, k, 1, int'($urandom_range(16'h4000, 16'h7FFF))));
        push(mk(2, 0, 0, 0));
        repeat (40) @(negedge clk);
        @(negedge clk);
        wr_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            din = mk(1, k, 1, 16'h7FFF);
            @(negedge clk);
        end
        wr_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({full, empty, dout, dir_out, en_out} !== {1'b0, 1'b1, 32'h0, 4'b0, 4'b0}) begin
            failures++;
            $display("FAIL async_reset: full=%b empty=%b dout=%h dir_out=%b en_out=%b required 0 1 0 0 0", full, empty, dout, dir_out, en_out);
        end
        foreach (m_duty[k]) begin
            m_duty[k] = 0;
            m_dir[k] = 1'b0;
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hi = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            hi += int'(|{dir_out, en_out});
        end
        checks++;
        if (hi != 0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL queued_discarded: %0d active cycles, empty=%b, required 0 and 1", hi, empty);
        end
    endtask

    initial begin
        test_reset;
        test_set_latency;
        test_pwm;
        test_get;
        test_dir_change;
        test_backpressure;
        test_random;
        test_reset_midstream;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
